// File: rtl/sik_stack_pkg.sv
// Shared types for the Sik operand-stack unit: opcodes, error codes, FSM states.
package sik_stack_pkg;

    // Command opcodes; 13..15 are left undefined and are rejected as illegal.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_PRE  = 4'd2,
        OP_POP  = 4'd3,
        OP_DUP  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_LT   = 4'd10,
        OP_TEST = 4'd11,
        OP_GET  = 4'd12
    } opcode_e;

    // Sticky error status reported to the sequencer.
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    // Control FSM: IDLE accepts commands, READ waits for the RAM word,
    // ERR is a dead end that only reset leaves.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Address width of the below-TOS RAM (DEPTH-1 words), never narrower than 1.
    function automatic int ram_addr_bits(input int depth);
        return (depth > 2) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/sik_stack_ram.sv
// Below-TOS storage: DEPTH-1 words, one write port, one registered read port.
module sik_stack_ram
    import sik_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = ram_addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH-1];

    // Write port and one-cycle-latency read port; the controller never
    // reads and writes the same address in one cycle.
    // NOTE: the array and its read register have no reset; stale contents
    // are never observable because count gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sik_stack_unit.sv
// Sik operand-stack engine: TOS register, below-TOS RAM, ALU and command FSM.
module sik_stack_unit
    import sik_stack_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int PRE_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [WIDTH-PRE_BITS-1:0]   cmd_imm,
    output logic [WIDTH-1:0]            tos,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        cond,
    output logic                        done,
    output logic [1:0]                  err_code
);

    localparam int IW = WIDTH - PRE_BITS;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = ram_addr_bits(DEPTH);
    // Common width for comparing the GET index against the entry count.
    localparam int KW = (IW > CW) ? IW : CW;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [KW-1:0] K_ONE    = KW'(1);

    // Architectural state
    state_e              state_q, state_d;
    opcode_e             op_q, op_d;
    logic [WIDTH-1:0]    tos_q, tos_d;
    logic [CW-1:0]       count_q, count_d;
    logic                cond_q, cond_d;
    logic [PRE_BITS-1:0] pre_q, pre_d;
    logic                pre_valid_q, pre_valid_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;

    // RAM port controls
    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [WIDTH-1:0]    ram_wdata;
    logic                ram_re;
    logic [AW-1:0]       ram_raddr;
    logic [WIDTH-1:0]    ram_rdata;

    // Decode helpers
    logic [KW-1:0]       k_ext;
    logic [KW-1:0]       cnt_ext;
    logic                cnt_zero;
    logic                cnt_lt2;
    logic                cnt_full;
    logic [WIDTH-1:0]    push_val;
    logic [WIDTH-1:0]    alu_res;

    assign k_ext    = KW'(cmd_imm);
    assign cnt_ext  = KW'(count_q);
    assign cnt_zero = (count_q == '0);
    assign cnt_lt2  = (count_q < CNT_TWO);
    assign cnt_full = (count_q == CNT_FULL);

    // A pending prefix supplies the top bits; otherwise the immediate is sign-extended.
    assign push_val = pre_valid_q ? {pre_q, cmd_imm}
                                  : {{PRE_BITS{cmd_imm[IW-1]}}, cmd_imm};

    sik_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ALU for the READ cycle: NOS arrives from the RAM, TOS is the right operand.
    // POP, TEST and GET simply take the loaded word.
    always_comb begin
        alu_res = ram_rdata;
        case (op_q)
            OP_ADD:  alu_res = ram_rdata + tos_q;
            OP_SUB:  alu_res = ram_rdata - tos_q;
            OP_AND:  alu_res = ram_rdata & tos_q;
            OP_OR:   alu_res = ram_rdata | tos_q;
            OP_XOR:  alu_res = ram_rdata ^ tos_q;
            OP_LT:   alu_res = WIDTH'($signed(ram_rdata) < $signed(tos_q));
            default: alu_res = ram_rdata;
        endcase
    end

    // Next-state, datapath and RAM control; errors are checked before execution.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tos_d       = tos_q;
        count_d     = count_q;
        cond_d      = cond_q;
        pre_d       = pre_q;
        pre_valid_d = pre_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        ram_we      = 1'b0;
        ram_waddr   = AW'(count_q - CNT_ONE);
        ram_wdata   = tos_q;
        ram_re      = 1'b0;
        ram_raddr   = AW'(count_q - CNT_TWO);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: begin
                            done_d = 1'b1;
                        end

                        OP_PUSH: begin
                            if (cnt_full) begin
                                err_d   = ERR_OVERFLOW;
                                state_d = ST_ERR;
                            end else begin
                                ram_we      = !cnt_zero;
                                tos_d       = push_val;
                                count_d     = count_q + CNT_ONE;
                                pre_valid_d = 1'b0;
                                done_d      = 1'b1;
                            end
                        end

                        OP_PRE: begin
                            pre_d       = cmd_imm[PRE_BITS-1:0];
                            pre_valid_d = 1'b1;
                            done_d      = 1'b1;
                        end

                        OP_DUP: begin
                            if (cnt_full) begin
                                err_d   = ERR_OVERFLOW;
                                state_d = ST_ERR;
                            end else if (cnt_zero) begin
                                err_d   = ERR_UNDERFLOW;
                                state_d = ST_ERR;
                            end else begin
                                ram_we  = 1'b1;
                                count_d = count_q + CNT_ONE;
                                done_d  = 1'b1;
                            end
                        end

                        OP_POP, OP_TEST: begin
                            if (cnt_zero) begin
                                err_d   = ERR_UNDERFLOW;
                                state_d = ST_ERR;
                            end else begin
                                if (cmd_op == OP_TEST) begin
                                    cond_d = |tos_q;
                                end
                                // Popping the last entry needs no RAM access.
                                if (count_q == CNT_ONE) begin
                                    tos_d   = '0;
                                    count_d = '0;
                                    done_d  = 1'b1;
                                end else begin
                                    ram_re  = 1'b1;
                                    op_d    = OP_POP;
                                    state_d = ST_READ;
                                end
                            end
                        end

                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT: begin
                            if (cnt_lt2) begin
                                err_d   = ERR_UNDERFLOW;
                                state_d = ST_ERR;
                            end else begin
                                ram_re  = 1'b1;
                                op_d    = opcode_e'(cmd_op);
                                state_d = ST_READ;
                            end
                        end

                        OP_GET: begin
                            if (cnt_full) begin
                                err_d   = ERR_OVERFLOW;
                                state_d = ST_ERR;
                            end else if (k_ext >= cnt_ext) begin
                                err_d   = ERR_UNDERFLOW;
                                state_d = ST_ERR;
                            end else if (k_ext == '0) begin
                                ram_we  = 1'b1;
                                count_d = count_q + CNT_ONE;
                                done_d  = 1'b1;
                            end else begin
                                // Spill TOS and fetch the k-th entry together;
                                // k >= 1 keeps the two addresses apart.
                                ram_we    = 1'b1;
                                ram_re    = 1'b1;
                                ram_raddr = AW'(cnt_ext - K_ONE - k_ext);
                                op_d      = OP_GET;
                                state_d   = ST_READ;
                            end
                        end

                        default: begin
                            err_d   = ERR_ILLEGAL;
                            state_d = ST_ERR;
                        end
                    endcase
                end
            end

            ST_READ: begin
                tos_d   = alu_res;
                count_d = (op_q == OP_GET) ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; an asynchronous reset aborts any op in flight.
    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            tos_q       <= '0;
            count_q     <= '0;
            cond_q      <= 1'b0;
            pre_q       <= '0;
            pre_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            cond_q      <= cond_d;
            pre_q       <= pre_d;
            pre_valid_q <= pre_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign tos       = tos_q;
    assign count     = count_q;
    assign cond      = cond_q;
    assign done      = done_q;
    assign err_code  = err_q;

endmodule

// File: doc/sik_stack_unit.md
# sik_stack_unit

- Parametrised operand-stack and ALU engine for the Sik stack processor.
- Top-of-stack (TOS) is held in a register; the rest of the stack lives in a synchronous 1W1R RAM.
- Executes push/pre/pop/dup/get and the binary ALU ops behind a valid/ready command handshake.
- Reports completion, the conditional flag (TorF) and sticky error status to the sequencer.

## Interface
- `WIDTH`, 16: data word width.
- `DEPTH`, 256: maximum stack entries, including TOS; must be ≥2.
- `PRE_BITS`, 4: prefix width; the immediate is `WIDTH-PRE_BITS` bits.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  unit accepts a command; high only in IDLE.
- `cmd_op`  in  4  opcode (package enum).
- `cmd_imm`  in  WIDTH-PRE_BITS  immediate, or k for GET.
- `tos`  out  WIDTH  current top of stack.
- `count`  out  $clog2(DEPTH+1)  current number of entries.
- `cond`  out  1  TorF flag.
- `done`  out  1  one-cycle pulse when an accepted command commits.
- `err_code`  out  2  0 none, 1 overflow, 2 underflow, 3 illegal opcode; sticky.

## Operation
- **Opcodes:** 0 NOP, 1 PUSH, 2 PRE, 3 POP, 4 DUP, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 LT, 11 TEST, 12 GET. Codes 13–15 are illegal.
- **RAM layout:** ram[i] for i = 0..count-2 holds the entries below TOS. NOS is ram[count-2].
- **PUSH:** value = pre_valid ? {pre, cmd_imm} : sign-extended cmd_imm. If count ≥ 1, write ram[count-1] ← tos. Then tos ← value, count+1, pre_valid ← 0.
- **PRE:** pre ← cmd_imm[PRE_BITS-1:0], pre_valid ← 1. A second PRE overwrites. Only PUSH consumes it.
- **DUP:** requires count ≥ 1. Writes ram[count-1] ← tos, count+1.
- **POP:** requires count ≥ 1.
  - count = 1: tos ← 0, count ← 0.
  - Otherwise: read NOS, then tos ← NOS, count-1.
- **Binary ops:** require count ≥ 2. Read NOS, then tos ← NOS op tos, count-1.
  - Arithmetic is modulo 2^WIDTH.
  - SUB computes NOS − tos.
  - LT is a signed compare and yields 1 or 0.
- **TEST:** requires count ≥ 1. cond ← (tos ≠ 0), then the entry is popped as for POP. No other op alters cond.
- **GET k:** requires k < count and count < DEPTH.
  - k = 0: behaves as DUP.
  - Otherwise: write ram[count-1] ← tos and read ram[count-1-k] in the same cycle (addresses are distinct). Then tos ← read data, count+1.
- **Error checks:** performed at acceptance; the error takes priority over execution.
  - Overflow: PUSH, DUP or GET with count = DEPTH.
  - Underflow: an op's count requirement is not met.
  - On error: stack, cond and pre are unchanged, done does not pulse, err_code is set and the FSM enters ERR.
- **FSM:**
  - IDLE → READ for two-cycle ops.
  - IDLE → ERR on error.
  - READ → IDLE unconditionally.
  - ERR is left only by reset.

## Timing
- **Reset values:** tos 0, count 0, cond 0, pre_valid 0, pre 0, done 0, err_code 0, state IDLE (so cmd_ready = 1). RAM contents are don't-care.
- **Acceptance:** a command is accepted at the rising edge with cmd_valid & cmd_ready.
- **Single-cycle ops** (NOP, PUSH, PRE, DUP, GET 0, and POP/TEST with count = 1): results are visible after the accepting edge N. done is high during cycle N+1. A new command may be accepted at edge N+1, giving full throughput.
- **Two-cycle ops:** cmd_ready is low during cycle N+1. Results are visible after edge N+1, and done is high during cycle N+2.
- **Error:** err_code is visible after edge N, and cmd_ready stays low thereafter.
- **RAM:** read latency is one cycle. The RAM is never read and written at the same address in the same cycle.
- **Reset during READ:** the op is aborted and all outputs return to their reset values immediately (asynchronous).

## Structure
- **Package `sik_stack_pkg`:** opcode enum, err_code constants, FSM state enum (IDLE, READ, ERR).
- **Sub-module `sik_stack_ram`:**
  - DEPTH-1 words of WIDTH bits.
  - One write port, one synchronous read port.
  - No reset.
- **Top:** all control logic, TOS/pre/cond registers and the ALU.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
- PUSH 5, PUSH 3, SUB → tos=0x0002, count=1. done pulses: cycles after edges 1 and 2, then two cycles after the SUB accept. cmd_ready low for one cycle.
- PRE 0xA, PUSH 0x123 → tos=0xA123. Then PUSH 0xFFF → tos=0xFFFF (sign-extended; pre already consumed).
- PUSH ×4, then PUSH 9 → err_code=1, count=4, tos unchanged, cmd_ready stays 0, no done.
- After reset, PUSH 1, ADD → err_code=2, tos=1, count=1.
- PUSH 0xFFF (−1), PUSH 1, LT → tos=1, count=1. Then TEST → cond=1, tos=0, count=0.
- PUSH 10, 20, 30; GET 2 → tos=10, count=4. Then POP, with reset driven low during its READ cycle → all outputs at reset values immediately, cmd_ready=1 after release.
